// File: rtl/alu_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Requester handshakes, shared response bus and ALU hookup for
//            alu_arbiter. The slave modport is the arbiter's view. The master
//            modport is the surrounding system: both requesters plus the ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
);
  // requester 0
  logic             input_Req0;
  logic [OPW-1:0]   input_Op0;
  logic [WIDTH-1:0] input_A0;
  logic [WIDTH-1:0] input_B0;
  logic             output_Gnt0;
  logic             output_Done0;
  // requester 1
  logic             input_Req1;
  logic [OPW-1:0]   input_Op1;
  logic [WIDTH-1:0] input_A1;
  logic [WIDTH-1:0] input_B1;
  logic             output_Gnt1;
  logic             output_Done1;
  // shared response
  logic [WIDTH-1:0] output_Result;
  logic             output_Zero;
  logic             output_Negative;
  logic             output_Error;
  logic             output_Busy;
  // ALU side
  logic [WIDTH-1:0] output_ALU_A;
  logic [WIDTH-1:0] output_ALU_B;
  logic [OPW-1:0]   output_ALU_Op;
  logic [WIDTH-1:0] input_ALU_Result;
  logic             input_ALU_Zero;
  logic             input_ALU_Negative;

  modport slave (
    input  input_Req0, input_Op0, input_A0, input_B0,
    input  input_Req1, input_Op1, input_A1, input_B1,
    input  input_ALU_Result, input_ALU_Zero, input_ALU_Negative,
    output output_Gnt0, output_Done0, output_Gnt1, output_Done1,
    output output_Result, output_Zero, output_Negative, output_Error, output_Busy,
    output output_ALU_A, output_ALU_B, output_ALU_Op
  );

  modport master (
    output input_Req0, input_Op0, input_A0, input_B0,
    output input_Req1, input_Op1, input_A1, input_B1,
    output input_ALU_Result, input_ALU_Zero, input_ALU_Negative,
    input  output_Gnt0, output_Done0, output_Gnt1, output_Done1,
    input  output_Result, output_Zero, output_Negative, output_Error, output_Busy,
    input  output_ALU_A, output_ALU_B, output_ALU_Op
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two
//            requesters. IDLE -> EXEC -> RESP, one cycle each. Operands are
//            registered on accept. The result and flags are captured in EXEC
//            and returned in RESP with a per-requester done pulse. Illegal
//            opcodes are flagged without sampling the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH  = 16,
  parameter int OPW    = 4,
  parameter int MAX_OP = 4
) (
  input  logic         input_CLK,
  input  logic         input_Reset,
  alu_arbiter_if.slave bus
);

  localparam logic [OPW-1:0] c_max_op = OPW'(MAX_OP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last;      // last winner; 1 after reset so requester 0 wins first tie
  logic             r_owner;     // requester that owns the operation in flight
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_neg;
  logic             r_error;
  logic             r_done0;
  logic             r_done1;
  logic             w_winner;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic             w_legal;

  // Winner selection and grants: a tie goes to the requester that did not win last.
  always_comb begin
    w_winner = 1'b0;
    if (bus.input_Req0 && bus.input_Req1) begin
      w_winner = ~r_last;
    end else if (bus.input_Req1) begin
      w_winner = 1'b1;
    end
    w_gnt0   = (r_state == S_IDLE) && bus.input_Req0 && !w_winner;
    w_gnt1   = (r_state == S_IDLE) && bus.input_Req1 &&  w_winner;
    w_accept = w_gnt0 || w_gnt1;
    w_legal  = (r_op <= c_max_op);
  end

  // Next-state logic: every state lasts exactly one cycle per operation.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge input_CLK or posedge input_Reset) begin
    if (input_Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand registers change only on accept, so the ALU inputs never glitch.
  always_ff @(posedge input_CLK or posedge input_Reset) begin
    if (input_Reset) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_accept) begin
      r_op    <= w_gnt1 ? bus.input_Op1 : bus.input_Op0;
      r_a     <= w_gnt1 ? bus.input_A1  : bus.input_A0;
      r_b     <= w_gnt1 ? bus.input_B1  : bus.input_B0;
      r_owner <= w_gnt1;
      r_last  <= w_gnt1;
    end
  end

  // Response capture in EXEC. Illegal opcodes never look at the ALU outputs.
  always_ff @(posedge input_CLK or posedge input_Reset) begin
    if (input_Reset) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_error  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      if (w_legal) begin
        r_result <= bus.input_ALU_Result;
        r_zero   <= bus.input_ALU_Zero;
        r_neg    <= bus.input_ALU_Negative;
        r_error  <= 1'b0;
      end else begin
        r_result <= '0;
        r_zero   <= 1'b0;
        r_neg    <= 1'b0;
        r_error  <= 1'b1;
      end
    end
  end

  // Done pulses: high only during RESP, for the owning requester.
  always_ff @(posedge input_CLK or posedge input_Reset) begin
    if (input_Reset) begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_done0 <= (r_state == S_EXEC) && !r_owner;
      r_done1 <= (r_state == S_EXEC) &&  r_owner;
    end
  end

  assign bus.output_Gnt0     = w_gnt0;
  assign bus.output_Gnt1     = w_gnt1;
  assign bus.output_Done0    = r_done0;
  assign bus.output_Done1    = r_done1;
  assign bus.output_Result   = r_result;
  assign bus.output_Zero     = r_zero;
  assign bus.output_Negative = r_neg;
  assign bus.output_Error    = r_error;
  assign bus.output_Busy     = (r_state != S_IDLE);
  assign bus.output_ALU_A    = r_a;
  assign bus.output_ALU_B    = r_b;
  assign bus.output_ALU_Op   = r_op;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter with a behavioural ALU and a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int WIDTH = 16;
  localparam int OPW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alu_x = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .MAX_OP(4)) dut (
    .input_CLK   (clk),
    .input_Reset (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; drives X on demand and junk for unused opcodes.
  logic [15:0] alu_r;
  always_comb begin
    alu_r = 16'hDEAD;
    case (bus.output_ALU_Op)
      4'd0: alu_r = bus.output_ALU_A + bus.output_ALU_B;
      4'd1: alu_r = bus.output_ALU_A - bus.output_ALU_B;
      4'd2: alu_r = bus.output_ALU_A & bus.output_ALU_B;
      4'd3: alu_r = bus.output_ALU_A | bus.output_ALU_B;
      4'd4: alu_r = bus.output_ALU_A ^ bus.output_ALU_B;
      default: alu_r = 16'hDEAD;
    endcase
    if (alu_x) begin
      bus.input_ALU_Result   = 'x;
      bus.input_ALU_Zero     = 1'bx;
      bus.input_ALU_Negative = 1'bx;
    end else begin
      bus.input_ALU_Result   = alu_r;
      bus.input_ALU_Zero     = (alu_r == 16'h0000);
      bus.input_ALU_Negative = alu_r[15];
    end
  end

  // Expected response value; illegal opcodes yield zero.
  function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.input_Req0 = 1'b0; bus.input_Op0 = '0; bus.input_A0 = '0; bus.input_B0 = '0;
    bus.input_Req1 = 1'b0; bus.input_Op1 = '0; bus.input_A1 = '0; bus.input_B1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] regs;
    clear_inputs();
    rst = 1'b1;
    #3;
    regs = {bus.output_Result, bus.output_ALU_A, bus.output_ALU_B, bus.output_ALU_Op,
            bus.output_Zero, bus.output_Negative, bus.output_Error, bus.output_Done0};
    checks++; if (regs !== 64'h0) begin failures++; $display("FAIL reset_regs: got %h expected 0", regs); end
    checks++; if (bus.output_Done1 !== 1'b0) begin failures++; $display("FAIL reset_done1: got %b expected 0", bus.output_Done1); end
    checks++; if (bus.output_Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.output_Busy); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({bus.output_Gnt0, bus.output_Gnt1} !== 2'b00) begin failures++; $display("FAIL reset_idle_gnt: got %b expected 00", {bus.output_Gnt0, bus.output_Gnt1}); end
  endtask

  task automatic test_single_add();
    bus.input_Req0 = 1'b1; bus.input_Op0 = 4'd0; bus.input_A0 = 16'h1234; bus.input_B0 = 16'h5678;
    #1;
    checks++; if ({bus.output_Gnt0, bus.output_Gnt1} !== 2'b10) begin failures++; $display("FAIL add_gnt: got %b expected 10", {bus.output_Gnt0, bus.output_Gnt1}); end
    tick();
    bus.input_Req0 = 1'b0; bus.input_A0 = 16'hFFFF; bus.input_Op0 = 4'd3;
    #1;
    checks++; if (bus.output_Busy !== 1'b1) begin failures++; $display("FAIL add_busy_exec: got %b expected 1", bus.output_Busy); end
    checks++; if ({bus.output_ALU_Op, bus.output_ALU_A, bus.output_ALU_B} !== {4'd0, 16'h1234, 16'h5678}) begin failures++; $display("FAIL add_alu_in: got %h expected 012345678", {bus.output_ALU_Op, bus.output_ALU_A, bus.output_ALU_B}); end
    checks++; if ({bus.output_Done0, bus.output_Done1} !== 2'b00) begin failures++; $display("FAIL add_done_early: got %b expected 00", {bus.output_Done0, bus.output_Done1}); end
    tick();
    checks++; if ({bus.output_Done0, bus.output_Done1, bus.output_Busy} !== 3'b101) begin failures++; $display("FAIL add_done: got %b expected 101", {bus.output_Done0, bus.output_Done1, bus.output_Busy}); end
    checks++; if ({bus.output_Result, bus.output_Zero, bus.output_Negative, bus.output_Error} !== {16'h68AC, 3'b000}) begin failures++; $display("FAIL add_result: got %h expected 68AC/000", {bus.output_Result, bus.output_Zero, bus.output_Negative, bus.output_Error}); end
    tick();
    checks++; if ({bus.output_Done0, bus.output_Busy} !== 2'b00) begin failures++; $display("FAIL add_after: got %b expected 00", {bus.output_Done0, bus.output_Busy}); end
    checks++; if (bus.output_Result !== 16'h68AC) begin failures++; $display("FAIL add_hold: got %h expected 68AC", bus.output_Result); end
  endtask

  task automatic test_round_robin();
    int last = 1;
    int w;
    logic [15:0] exp_r;
    do_reset();
    bus.input_Req0 = 1'b1; bus.input_Op0 = 4'd1; bus.input_A0 = 16'h5678; bus.input_B0 = 16'h1234;
    bus.input_Req1 = 1'b1; bus.input_Op1 = 4'd2; bus.input_A1 = 16'hAAAA; bus.input_B1 = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      w = 1 - last;
      exp_r = (w == 0) ? 16'h4444 : 16'h0000;
      #1;
      checks++; if ({bus.output_Gnt0, bus.output_Gnt1} !== ((w == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_gnt[%0d]: got %b expected winner %0d", i, {bus.output_Gnt0, bus.output_Gnt1}, w); end
      tick();
      tick();
      checks++; if ({bus.output_Done0, bus.output_Done1} !== ((w == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_done[%0d]: got %b expected owner %0d", i, {bus.output_Done0, bus.output_Done1}, w); end
      checks++; if ({bus.output_Result, bus.output_Zero} !== {exp_r, (w == 1)}) begin failures++; $display("FAIL rr_result[%0d]: got %h/%b expected %h/%b", i, bus.output_Result, bus.output_Zero, exp_r, (w == 1)); end
      last = w;
      tick();
    end
  endtask

  task automatic test_or_stream();
    bus.input_Req0 = 1'b0;
    bus.input_Req1 = 1'b1; bus.input_Op1 = 4'd3; bus.input_A1 = 16'hAAAA; bus.input_B1 = 16'h5555;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++; if ({bus.output_Gnt0, bus.output_Gnt1} !== {1'b0, (i % 3 == 0)}) begin failures++; $display("FAIL or_gnt[%0d]: got %b expected 0%b", i, {bus.output_Gnt0, bus.output_Gnt1}, (i % 3 == 0)); end
      if (i % 3 == 2) begin
        checks++; if ({bus.output_Done1, bus.output_Result, bus.output_Negative, bus.output_Zero} !== {1'b1, 16'hFFFF, 2'b10}) begin failures++; $display("FAIL or_resp[%0d]: got %b %h N%b Z%b expected 1 FFFF N1 Z0", i, bus.output_Done1, bus.output_Result, bus.output_Negative, bus.output_Zero); end
      end
      tick();
    end
    bus.input_Req1 = 1'b0;
  endtask

  task automatic test_illegal();
    alu_x = 1'b1;
    bus.input_Req0 = 1'b1; bus.input_Op0 = 4'hF; bus.input_A0 = 16'(($urandom)); bus.input_B0 = 16'(($urandom));
    #1;
    checks++; if (bus.output_Gnt0 !== 1'b1) begin failures++; $display("FAIL ill_gnt: got %b expected 1", bus.output_Gnt0); end
    tick();
    bus.input_Req0 = 1'b0;
    tick();
    checks++; if ({bus.output_Done0, bus.output_Error} !== 2'b11) begin failures++; $display("FAIL ill_done_err: got %b expected 11", {bus.output_Done0, bus.output_Error}); end
    checks++; if ({bus.output_Result, bus.output_Zero, bus.output_Negative} !== {16'h0000, 2'b00}) begin failures++; $display("FAIL ill_result: got %h expected 0", {bus.output_Result, bus.output_Zero, bus.output_Negative}); end
    tick();
    alu_x = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] regs;
    bus.input_Req1 = 1'b1; bus.input_Op1 = 4'd4; bus.input_A1 = 16'h0F0F; bus.input_B1 = 16'h00FF;
    #1;
    checks++; if (bus.output_Gnt1 !== 1'b1) begin failures++; $display("FAIL rst_gnt1: got %b expected 1", bus.output_Gnt1); end
    tick();
    bus.input_Req1 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    regs = {bus.output_Result, bus.output_ALU_A, bus.output_ALU_B, bus.output_ALU_Op,
            bus.output_Zero, bus.output_Negative, bus.output_Error, bus.output_Done1};
    checks++; if ({regs, bus.output_Busy, bus.output_Done0} !== 66'h0) begin failures++; $display("FAIL rst_mid_outputs: got %h expected 0", {regs, bus.output_Busy, bus.output_Done0}); end
    tick();
    tick();
    bus.input_Req0 = 1'b1; bus.input_Op0 = 4'd0; bus.input_A0 = 16'h0001; bus.input_B0 = 16'h0002;
    bus.input_Req1 = 1'b1; bus.input_Op1 = 4'd4; bus.input_A1 = 16'h0F0F; bus.input_B1 = 16'h00FF;
    rst = 1'b0;
    #1;
    checks++; if ({bus.output_Gnt0, bus.output_Gnt1} !== 2'b10) begin failures++; $display("FAIL rst_after_gnt: got %b expected 10", {bus.output_Gnt0, bus.output_Gnt1}); end
    tick();
    bus.input_Req0 = 1'b0;
    tick();
    checks++; if ({bus.output_Done0, bus.output_Done1, bus.output_Result} !== {2'b10, 16'h0003}) begin failures++; $display("FAIL rst_after_done: got %h expected 2/0003", {bus.output_Done0, bus.output_Done1, bus.output_Result}); end
    tick();
    #1;
    checks++; if (bus.output_Gnt1 !== 1'b1) begin failures++; $display("FAIL rst_rerequest_gnt1: got %b expected 1", bus.output_Gnt1); end
    tick();
    bus.input_Req1 = 1'b0;
    tick();
    checks++; if ({bus.output_Done1, bus.output_Result} !== {1'b1, 16'h0FF0}) begin failures++; $display("FAIL rst_rerequest_done1: got %h expected 1/0FF0", {bus.output_Done1, bus.output_Result}); end
    tick();
  endtask

  task automatic test_busy_stability();
    logic [3:0]  op;
    logic [15:0] a, b;
    op = 4'(($urandom_range(0, 4))); a = 16'(($urandom)); b = 16'(($urandom));
    bus.input_Req1 = 1'b1; bus.input_Op1 = op; bus.input_A1 = a; bus.input_B1 = b;
    #1;
    checks++; if ({bus.output_Gnt1, bus.output_Busy} !== 2'b10) begin failures++; $display("FAIL stab_gnt: got %b expected 10", {bus.output_Gnt1, bus.output_Busy}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.input_Req1 = 1'b0; bus.input_Op1 = ~op; bus.input_A1 = ~a; bus.input_B1 = 16'(($urandom));
      bus.input_Op0 = 4'(($urandom)); bus.input_A0 = 16'(($urandom));
      #1;
      checks++; if ({bus.output_Busy, bus.output_ALU_Op, bus.output_ALU_A, bus.output_ALU_B} !== {1'b1, op, a, b}) begin failures++; $display("FAIL stab_alu_in[%0d]: got %h expected %h", i, {bus.output_Busy, bus.output_ALU_Op, bus.output_ALU_A, bus.output_ALU_B}, {1'b1, op, a, b}); end
    end
    tick();
    checks++; if (bus.output_Busy !== 1'b0) begin failures++; $display("FAIL stab_busy_idle: got %b expected 0", bus.output_Busy); end
  endtask

  // Randomized two-requester traffic against a transaction-level model.
  task automatic test_random();
    logic        pend [2];
    logic [3:0]  rop  [2];
    logic [15:0] ra   [2];
    logic [15:0] rb   [2];
    logic        gprev[2];
    int phase, owner, last;
    logic eg0, eg1;
    logic [3:0]  cop;
    logic [15:0] ca, cb, er;
    logic        legal;
    do_reset();
    phase = 0; owner = 0; last = 1; cop = '0; ca = '0; cb = '0;
    for (int k = 0; k < 2; k++) begin pend[k] = 1'b0; gprev[k] = 1'b0; rop[k] = '0; ra[k] = '0; rb[k] = '0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (gprev[k]) pend[k] = ($urandom_range(0, 3) == 0);
        else if (!pend[k]) pend[k] = ($urandom_range(0, 2) == 0);
        if (gprev[k] || !pend[k] || !(pend[k] && !gprev[k] && cyc > 0 && rop[k] !== 4'bx && 1'b1 && pend[k] === 1'b1 && gprev[k] === 1'b0 && 1'b0)) begin
          if (!(pend[k] && !gprev[k] && cyc > 0)) begin
            rop[k] = 4'(($urandom_range(0, 7))); ra[k] = 16'(($urandom)); rb[k] = 16'(($urandom));
          end
        end
      end
      bus.input_Req0 = pend[0]; bus.input_Op0 = rop[0]; bus.input_A0 = ra[0]; bus.input_B0 = rb[0];
      bus.input_Req1 = pend[1]; bus.input_Op1 = rop[1]; bus.input_A1 = ra[1]; bus.input_B1 = rb[1];
      #1;
      eg0 = (phase == 0) && pend[0] && (!pend[1] || last == 1);
      eg1 = (phase == 0) && pend[1] && (!pend[0] || last == 0);
      checks++; if ({bus.output_Gnt0, bus.output_Gnt1} !== {eg0, eg1}) begin failures++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", cyc, {bus.output_Gnt0, bus.output_Gnt1}, {eg0, eg1}); end
      checks++; if ({bus.output_Busy, bus.output_Done0, bus.output_Done1} !== {(phase != 0), (phase == 2 && owner == 0), (phase == 2 && owner == 1)}) begin failures++; $display("FAIL rnd_ctrl[%0d]: got %b expected busy/done for phase %0d owner %0d", cyc, {bus.output_Busy, bus.output_Done0, bus.output_Done1}, phase, owner); end
      if (phase != 0) begin
        checks++; if ({bus.output_ALU_Op, bus.output_ALU_A, bus.output_ALU_B} !== {cop, ca, cb}) begin failures++; $display("FAIL rnd_alu_in[%0d]: got %h expected %h", cyc, {bus.output_ALU_Op, bus.output_ALU_A, bus.output_ALU_B}, {cop, ca, cb}); end
      end
      if (phase == 2) begin
        legal = (cop <= 4'd4);
        er = ref_result(cop, ca, cb);
        checks++; if ({bus.output_Result, bus.output_Zero, bus.output_Negative, bus.output_Error} !== {er, legal && (er == 16'h0), legal && er[15], !legal}) begin failures++; $display("FAIL rnd_resp[%0d]: got %h expected %h (op %0d)", cyc, {bus.output_Result, bus.output_Zero, bus.output_Negative, bus.output_Error}, {er, legal && (er == 16'h0), legal && er[15], !legal}, cop); end
      end
      if (phase == 0 && (eg0 || eg1)) begin
        owner = eg1 ? 1 : 0; last = owner;
        cop = rop[owner]; ca = ra[owner]; cb = rb[owner];
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2) begin
        phase = 0;
      end
      gprev[0] = eg0; gprev[1] = eg1;
      tick();
    end
    clear_inputs();
    tick();
    tick();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_add();
    test_round_robin();
    test_or_stream();
    test_illegal();
    test_reset_mid_op();
    test_busy_stability();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
